// File: rtl/alu_serial_pkg.sv
// Shared constants and state encoding for the bit-serial ALU sequencer.
package alu_serial_pkg;

    localparam logic [2:0] MODE_PLUS       = 3'd0;
    localparam logic [2:0] MODE_AND        = 3'd1;
    localparam logic [2:0] MODE_OR         = 3'd2;
    localparam logic [2:0] MODE_XOR        = 3'd3;
    localparam logic [2:0] MODE_XNOR       = 3'd4;
    localparam logic [2:0] MODE_LAST_LEGAL = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode <= MODE_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/mode_decoder3.sv
// 3-to-8 one-hot decoder; its output is registered by the sequencer before reaching the slice.
module mode_decoder3 (
    input  logic [2:0] mode,
    output logic [7:0] onehot
);

    // Single-bit set at the position selected by mode
    always_comb begin
        onehot       = 8'h00;
        onehot[mode] = 1'b1;
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a 1-bit ALU slice LSB first, returning the result over valid/ready.
// Optional zero/ovf flag outputs are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    output logic             ready,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
`ifdef ALU_SERIAL_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic [7:0]       decoder_x,
    output logic             alu_A,
    output logic             alu_B,
    output logic             alu_C_in,
    input  logic             alu_X,
    input  logic             alu_C_out
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               carry_q,   carry_d;
    logic [2:0]         mode_q,    mode_d;
    logic [7:0]         dec_q,     dec_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               err_q,     err_d;
    logic               valid_q,   valid_d;
    logic               ready_q,   ready_d;
    logic [7:0]         dec_in_s;
`ifdef ALU_SERIAL_FLAGS_EN
    logic               a_msb_q,   a_msb_d;
    logic               b_msb_q,   b_msb_d;
    logic               zero_q,    zero_d;
    logic               ovf_q,     ovf_d;
`endif

    mode_decoder3 u_mode_decoder3 (
        .mode   (Mode),
        .onehot (dec_in_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        dec_d     = dec_q;
        bit_cnt_d = bit_cnt_q;
        err_d     = err_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
`ifdef ALU_SERIAL_FLAGS_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    mode_d    = Mode;
                    dec_d     = dec_in_s;
                    carry_d   = 1'b0;
                    bit_cnt_d = '0;
                    result_d  = '0;
                    ready_d   = 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
                    a_msb_d   = A_in[WIDTH-1];
                    b_msb_d   = B_in[WIDTH-1];
                    zero_d    = 1'b0;
                    ovf_d     = 1'b0;
`endif
                    if (mode_is_legal(Mode)) begin
                        a_d     = A_in;
                        b_d     = B_in;
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        // Zero operands keep the slice inputs quiet while the error result is held
                        a_d     = '0;
                        b_d     = '0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
`ifdef ALU_SERIAL_FLAGS_EN
                        zero_d  = 1'b1;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d       = {1'b0, a_q[WIDTH-1:1]};
                b_d       = {1'b0, b_q[WIDTH-1:1]};
                result_d  = {alu_X, result_q[WIDTH-1:1]};
                carry_d   = (mode_q == MODE_PLUS) ? alu_C_out : 1'b0;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_d  = (result_d == '0);
                    ovf_d   = (mode_q == MODE_PLUS) && (a_msb_q == b_msb_q) &&
                              (result_d[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    dec_d   = 8'h00;
                    err_d   = 1'b0;
                    carry_d = 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
                dec_d   = 8'h00;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            mode_q    <= 3'd0;
            dec_q     <= 8'h00;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            dec_q     <= dec_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
`ifdef ALU_SERIAL_FLAGS_EN
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign res_valid = valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign err       = err_q;
    assign decoder_x = dec_q;
    assign alu_A     = a_q[0];
    assign alu_B     = b_q[0];
    assign alu_C_in  = carry_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl driving a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic [2:0] Mode = 3'd0;
    logic [7:0] A_in = 8'h00;
    logic [7:0] B_in = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] result;
    logic       carry;
    logic       err;
    logic [7:0] decoder_x;
    logic       alu_A, alu_B, alu_C_in;
    logic       alu_X, alu_C_out;
`ifdef ALU_SERIAL_FLAGS_EN
    logic       zero, ovf;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .ready     (ready),
        .Mode      (Mode),
        .A_in      (A_in),
        .B_in      (B_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry     (carry),
        .err       (err),
`ifdef ALU_SERIAL_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .decoder_x (decoder_x),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_C_in  (alu_C_in),
        .alu_X     (alu_X),
        .alu_C_out (alu_C_out)
    );

    always #5 CLK = ~CLK;

    // Behavioural 1-bit ALU slice acting as the real load
    always_comb begin
        alu_X     = 1'b0;
        alu_C_out = 1'b0;
        case (decoder_x)
            8'h01: begin
                alu_X     = alu_A ^ alu_B ^ alu_C_in;
                alu_C_out = (alu_A & alu_B) | (alu_C_in & (alu_A ^ alu_B));
            end
            8'h02:   alu_X = alu_A & alu_B;
            8'h04:   alu_X = alu_A | alu_B;
            8'h08:   alu_X = alu_A ^ alu_B;
            8'h10:   alu_X = ~(alu_A ^ alu_B);
            default: alu_X = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, no bit sequencing
    task automatic model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic e);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        r = 8'h00; c = 1'b0; e = 1'b0;
        case (m)
            3'd0:    begin r = sum[7:0]; c = sum[8]; end
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a ^ b);
            default: e = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] er;
        logic       ec, ee;
        int         n;
        model(m, a, b, er, ec, ee);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        check("ready_idle", ready, 1);
        Mode = m; A_in = a; B_in = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; A_in = 8'($urandom); B_in = 8'($urandom); Mode = 3'($urandom);
        check("dec_latched", decoder_x, 8'h01 << m);
        check("ready_busy", ready, 0);
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin
            if (n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
            @(posedge CLK); #1; n++;
        end
        start = 1'b0;
        check("latency", n, ee ? 0 : 8);
        check("result", result, er);
        check("carry", carry, ec);
        check("err", err, ee);
        check("dec_done", decoder_x, 8'h01 << m);
`ifdef ALU_SERIAL_FLAGS_EN
        check("zero", zero, er == 8'h00);
        check("ovf", ovf, (m == 3'd0) && (a[7] == b[7]) && (er[7] != a[7]));
`endif
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0; start = 1'b1; Mode = 3'($urandom);
            @(posedge CLK); #1;
            check("hold_valid", res_valid, 1);
            check("hold_result", result, er);
        end
        res_ready = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        res_ready = 1'b0; start = 1'b0;
        check("post_valid", res_valid, 0);
        check("post_ready", ready, 1);
        check("post_dec", decoder_x, 8'h00);
    endtask

    initial begin
        int n;
        logic seen;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_result", result, 8'h00);
        check("rst_carry", carry, 0);
        check("rst_err", err, 0);
        check("rst_dec", decoder_x, 8'h00);
        check("rst_alu", {alu_A, alu_B, alu_C_in}, 3'b000);
        RST = 1'b0;
        @(posedge CLK); #1;

        run_op(3'd0, 8'h5A, 8'h3C, 0);
        run_op(3'd0, 8'hFF, 8'h01, 1);
        run_op(3'd1, 8'hF0, 8'h3C, 0);
        run_op(3'd4, 8'hA5, 8'h0F, 3);
        run_op(3'd6, 8'h12, 8'h34, 2);
        run_op(3'd0, 8'h7F, 8'h01, 0);
        run_op(3'd0, 8'h80, 8'h80, 0);

        // Reset while bit 3 is on the slice
        Mode = 3'd0; A_in = 8'h11; B_in = 8'h22; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_dec", decoder_x, 8'h00);
        check("midrst_valid", res_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        run_op(3'd0, 8'h5A, 8'h3C, 0);

        for (int k = 0; k < 25; k++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
